// File: rtl/spi_slave_if.sv
// SPI pin bundle plus the parallel word/status side of the SPI slave.
// The slave modport is the view taken by spi_slave; the master modport is the outside view.
interface spi_slave_if;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;
  logic [15:0] tx_data;
  logic [15:0] rx_data;
  logic        rdy;
  logic        frm_err;
  logic        clr_err;
  logic        busy;

  modport slave (
    input  SS_n, SCLK, MOSI, tx_data, clr_err,
    output MISO, rx_data, rdy, frm_err, busy
  );

  modport master (
    output SS_n, SCLK, MOSI, tx_data, clr_err,
    input  MISO, rx_data, rdy, frm_err, busy
  );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-3 style slave, 16-bit frames, oversampled by clk.
// Pins are synchronized and edge-detected; a two-state FSM frames the transfer on SS_n.
module spi_slave (
  input  logic        clk,
  input  logic        rst,
  spi_slave_if.slave  bus
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t      state_q, state_d;
  logic        ss_s1_q, ss_s2_q, ss_s3_q;
  logic        sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic        mosi_s1_q, mosi_s2_q;
  logic        ss_fall_q, ss_fall_d;
  logic        ss_rise_q, ss_rise_d;
  logic        sclk_rise_q, sclk_rise_d;
  logic [1:0]  flush_q, flush_d;
  logic        armed_q, armed_d;
  logic [15:0] shift_q, shift_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] rx_q, rx_d;
  logic        rdy_q, rdy_d;
  logic        frm_err_q, frm_err_d;
  logic        err_event;

  // Registered edge strobes sit one clk behind the synchronizer compare.
  always_comb begin
    ss_fall_d   = ss_s3_q & ~ss_s2_q;
    ss_rise_d   = ~ss_s3_q & ss_s2_q;
    sclk_rise_d = ~sclk_s3_q & sclk_s2_q;
    flush_d     = (flush_q == 2'd3) ? flush_q : flush_q + 2'd1;
    // A frame may only start once SS_n has been seen high after reset.
    armed_d     = armed_q | ((flush_q == 2'd3) & ss_s2_q & ss_s3_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_s1_q     <= 1'b1;
      ss_s2_q     <= 1'b1;
      ss_s3_q     <= 1'b1;
      sclk_s1_q   <= 1'b1;
      sclk_s2_q   <= 1'b1;
      sclk_s3_q   <= 1'b1;
      mosi_s1_q   <= 1'b0;
      mosi_s2_q   <= 1'b0;
      ss_fall_q   <= 1'b0;
      ss_rise_q   <= 1'b0;
      sclk_rise_q <= 1'b0;
      flush_q     <= 2'd0;
      armed_q     <= 1'b0;
    end else begin
      ss_s1_q     <= bus.SS_n;
      ss_s2_q     <= ss_s1_q;
      ss_s3_q     <= ss_s2_q;
      sclk_s1_q   <= bus.SCLK;
      sclk_s2_q   <= sclk_s1_q;
      sclk_s3_q   <= sclk_s2_q;
      mosi_s1_q   <= bus.MOSI;
      mosi_s2_q   <= mosi_s1_q;
      ss_fall_q   <= ss_fall_d;
      ss_rise_q   <= ss_rise_d;
      sclk_rise_q <= sclk_rise_d;
      flush_q     <= flush_d;
      armed_q     <= armed_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    rx_d      = rx_q;
    rdy_d     = 1'b0;
    err_event = 1'b0;
    case (state_q)
      IDLE: begin
        // A coincident SCLK rise is dropped because only the load path runs here.
        if (ss_fall_q && armed_q) begin
          state_d = ACTIVE;
          shift_d = bus.tx_data;
          cnt_d   = 5'd0;
        end
      end
      ACTIVE: begin
        if (ss_rise_q) begin
          state_d = IDLE;
          if (cnt_q == 5'd16) begin
            rx_d  = shift_q;
            rdy_d = 1'b1;
          end else begin
            err_event = 1'b1;
          end
        end else if (sclk_rise_q) begin
          shift_d = {shift_q[14:0], mosi_s2_q};
          cnt_d   = (cnt_q == 5'd31) ? cnt_q : cnt_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // An error in the same clk as clr_err wins.
    frm_err_d = err_event | (frm_err_q & ~bus.clr_err);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= 16'h0000;
      cnt_q     <= 5'd0;
      rx_q      <= 16'h0000;
      rdy_q     <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      rx_q      <= rx_d;
      rdy_q     <= rdy_d;
      frm_err_q <= frm_err_d;
    end
  end

  assign bus.MISO    = shift_q[15];
  assign bus.rx_data = rx_q;
  assign bus.rdy     = rdy_q;
  assign bus.frm_err = frm_err_q;
  assign bus.busy    = (state_q == ACTIVE);

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a frame-level master model schedules expected
// output events by clk index, and a negedge process compares every cycle.
module tb_spi_slave;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_slave_if bus_if ();

  spi_slave dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // Expected events, stamped with the clk index at which they must be visible.
  int          ev_start_cyc = -1;
  int          ev_end_cyc   = -1;
  int          ev_clr_cyc   = -1;
  logic [15:0] ev_end_rx    = 16'h0000;
  bit          ev_end_ok    = 1'b0;

  logic [15:0] model_rx   = 16'h0000;
  bit          model_err  = 1'b0;
  bit          model_busy = 1'b0;
  int          rdy_cnt    = 0;

  // Master-side view of the current frame.
  bit          armed     = 1'b0;
  bit          active    = 1'b0;
  int          sent_n    = 0;
  int          miso_n    = 0;
  logic [15:0] sent_word = 16'h0000;
  logic [15:0] frame_tx  = 16'h0000;
  logic [15:0] miso_word = 16'h0000;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    bit exp_rdy;
    exp_rdy = 1'b0;
    if (rst) begin
      model_rx   = 16'h0000;
      model_err  = 1'b0;
      model_busy = 1'b0;
      chk("reset_miso", {31'd0, bus_if.MISO}, 32'd0);
    end else begin
      if (cyc == ev_start_cyc) model_busy = 1'b1;
      if (cyc == ev_clr_cyc) model_err = 1'b0;
      if (cyc == ev_end_cyc) begin
        model_busy = 1'b0;
        if (ev_end_ok) begin
          model_rx = ev_end_rx;
          exp_rdy  = 1'b1;
        end else begin
          model_err = 1'b1;
        end
      end
    end
    if (bus_if.rdy) rdy_cnt++;
    chk("rdy",     {31'd0, bus_if.rdy},     {31'd0, exp_rdy});
    chk("rx_data", {16'd0, bus_if.rx_data}, {16'd0, model_rx});
    chk("frm_err", {31'd0, bus_if.frm_err}, {31'd0, model_err});
    chk("busy",    {31'd0, bus_if.busy},    {31'd0, model_busy});
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ss_lower();
    bus_if.SS_n = 1'b0;
    sent_n      = 0;
    miso_n      = 0;
    sent_word   = 16'h0000;
    miso_word   = 16'h0000;
    if (armed) begin
      active       = 1'b1;
      frame_tx     = bus_if.tx_data;
      ev_start_cyc = cyc + 4;
    end
    tick(8);
  endtask

  task automatic send_bits(input logic [31:0] data, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bus_if.SCLK = 1'b0;
      bus_if.MOSI = data[i];
      tick(8);
      if (miso_n < 16) begin
        miso_word = {miso_word[14:0], bus_if.MISO};
        miso_n++;
      end
      bus_if.SCLK = 1'b1;
      if (active) begin
        sent_n++;
        sent_word = {sent_word[14:0], data[i]};
      end
      tick(8);
    end
  endtask

  task automatic ss_raise();
    tick(8);
    bus_if.SS_n = 1'b1;
    if (active) begin
      if (miso_n > 0) chk("miso_bits", {16'd0, miso_word}, {16'd0, frame_tx >> (16 - miso_n)});
      ev_end_cyc = cyc + 4;
      ev_end_ok  = (sent_n == 16);
      ev_end_rx  = sent_word;
      active     = 1'b0;
    end
    armed = 1'b1;
    tick(32);
  endtask

  task automatic clear_err();
    bus_if.clr_err = 1'b1;
    ev_clr_cyc     = cyc + 1;
    tick(1);
    bus_if.clr_err = 1'b0;
    tick(2);
  endtask

  initial begin
    int rdy_before;
    rst            = 1'b1;
    bus_if.SS_n    = 1'b1;
    bus_if.SCLK    = 1'b1;
    bus_if.MOSI    = 1'b0;
    bus_if.tx_data = 16'h0000;
    bus_if.clr_err = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(8);
    armed = 1'b1;

    // Nominal frame.
    bus_if.tx_data = 16'hA55A;
    ss_lower();
    send_bits(32'h3C0F, 16);
    ss_raise();
    chk("f1_rx_lit", {16'd0, bus_if.rx_data}, 32'h3C0F);
    chk("f1_miso_lit", {16'd0, miso_word}, 32'hA55A);
    chk("f1_rdy_cnt", rdy_cnt, 1);
    chk("f1_err_lit", {31'd0, bus_if.frm_err}, 0);
    $display("frame 16'h3C0F: rx_data=%h miso=%h rdy_cnt=%0d", bus_if.rx_data, miso_word, rdy_cnt);

    // Short frame.
    ss_lower();
    send_bits(32'hABC, 12);
    ss_raise();
    chk("short_err_lit", {31'd0, bus_if.frm_err}, 1);
    chk("short_rx_lit", {16'd0, bus_if.rx_data}, 32'h3C0F);
    chk("short_rdy_cnt", rdy_cnt, 1);
    clear_err();
    chk("short_clr_lit", {31'd0, bus_if.frm_err}, 0);
    $display("frame 12 bits: frm_err set then cleared, rx_data=%h", bus_if.rx_data);

    // Long frame followed by a good one; error stays sticky.
    ss_lower();
    send_bits(32'h12345, 17);
    ss_raise();
    chk("long_err_lit", {31'd0, bus_if.frm_err}, 1);
    chk("long_rdy_cnt", rdy_cnt, 1);
    ss_lower();
    send_bits(32'h00FF, 16);
    ss_raise();
    chk("after_long_rx_lit", {16'd0, bus_if.rx_data}, 32'h00FF);
    chk("after_long_err_lit", {31'd0, bus_if.frm_err}, 1);
    chk("after_long_rdy_cnt", rdy_cnt, 2);
    $display("frame 17 bits then 16'h00FF: rx_data=%h frm_err=%0d", bus_if.rx_data, bus_if.frm_err);

    // SCLK activity with SS_n high.
    for (int i = 0; i < 8; i++) begin
      bus_if.SCLK = 1'b0;
      bus_if.MOSI = ~bus_if.MOSI;
      tick(8);
      bus_if.SCLK = 1'b1;
      tick(8);
    end
    chk("idle_sclk_rx_lit", {16'd0, bus_if.rx_data}, 32'h00FF);
    chk("idle_sclk_err_lit", {31'd0, bus_if.frm_err}, 1);
    chk("idle_sclk_rdy_cnt", rdy_cnt, 2);
    $display("idle SCLK x8: busy=%0d rx_data=%h", bus_if.busy, bus_if.rx_data);
    clear_err();

    // Reset in the middle of a frame with SS_n held low.
    ss_lower();
    send_bits(32'hA5, 8);
    rst          = 1'b1;
    ev_start_cyc = -1;
    ev_end_cyc   = -1;
    ev_clr_cyc   = -1;
    active       = 1'b0;
    armed        = 1'b0;
    tick(3);
    chk("rst_mid_rx_lit", {16'd0, bus_if.rx_data}, 0);
    chk("rst_mid_miso_lit", {31'd0, bus_if.MISO}, 0);
    rst = 1'b0;
    rdy_before = rdy_cnt;
    tick(10);
    ss_raise();
    chk("rst_no_rdy", rdy_cnt, rdy_before);
    ss_lower();
    send_bits(32'h1234, 16);
    ss_raise();
    chk("rst_then_rx_lit", {16'd0, bus_if.rx_data}, 32'h1234);
    chk("rst_then_rdy_cnt", rdy_cnt, rdy_before + 1);
    $display("reset mid-frame then 16'h1234: rx_data=%h", bus_if.rx_data);

    // Back-to-back frames; tx_data changes during the first.
    bus_if.tx_data = 16'h1111;
    rdy_before = rdy_cnt;
    ss_lower();
    send_bits(32'hFF, 8);
    bus_if.tx_data = 16'h2222;
    send_bits(32'hFF, 8);
    ss_raise();
    chk("b2b1_rx_lit", {16'd0, bus_if.rx_data}, 32'hFFFF);
    chk("b2b1_miso_lit", {16'd0, miso_word}, 32'h1111);
    ss_lower();
    send_bits(32'h0001, 16);
    ss_raise();
    chk("b2b2_rx_lit", {16'd0, bus_if.rx_data}, 32'h0001);
    chk("b2b2_miso_lit", {16'd0, miso_word}, 32'h2222);
    chk("b2b_rdy_cnt", rdy_cnt, rdy_before + 2);
    $display("back-to-back 16'hFFFF/16'h0001: rx_data=%h miso=%h", bus_if.rx_data, miso_word);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
